hazard_tracker: RTL and testbench

- Produces the hazard inputs that the control decoder consumes: load_use, ex_collision_a/b and dm_collision_a/b.
- Tracks the destination register of the instructions in flight in the EX and DM stages with a two-entry shadow pipeline.
- Compares those destinations against the source registers of the instruction currently in ID.
- Keeps registered statistics counters for load-use stall cycles and flush cycles.

---
 rtl/hazard_tracker_pkg.sv | 32 +++
 rtl/hazard_tracker_if.sv | 43 ++++
 rtl/hazard_tracker_match.sv | 21 ++
 rtl/hazard_tracker.sv | 69 ++++++
 tb/tb_hazard_tracker.sv | 113 +++++++++++
 5 files changed

// File: rtl/hazard_tracker_pkg.sv
// Shared constants and entry layout for the hazard tracker.
// An entry is packed as {valid, w_en, dest, is_load}, with is_load in bit 0.
package hazard_tracker_pkg;

  localparam int HZ_REG_ADDR_BIT = 5;
  localparam int HZ_CNT_BIT      = 32;
  localparam int HZ_NUM_STG      = 2;
  localparam int HZ_NUM_SRC      = 2;

  localparam int HZ_LOAD_OFS = 0;
  localparam int HZ_DEST_OFS = 1;

  function automatic int hz_wen_ofs(input int aw);
    return aw + 1;
  endfunction

  function automatic int hz_valid_ofs(input int aw);
    return aw + 2;
  endfunction

  function automatic int hz_entry_bit(input int aw);
    return aw + 3;
  endfunction

  localparam int HZ_ENTRY_BIT = hz_entry_bit(HZ_REG_ADDR_BIT);

  typedef enum logic {
    STG_EX = 1'b0,
    STG_DM = 1'b1
  } hz_stage_e;

endpackage

// File: rtl/hazard_tracker_if.sv
// ID-stage request / hazard-output bundle between the pipeline front end
// and the hazard tracker.
interface hazard_tracker_if
  import hazard_tracker_pkg::*;
#(
  parameter int REG_ADDR_BIT = HZ_REG_ADDR_BIT,
  parameter int CNT_BIT      = HZ_CNT_BIT
);

  logic                    hold;
  logic                    flush;
  logic                    id_valid;
  logic [REG_ADDR_BIT-1:0] id_req_a;
  logic [REG_ADDR_BIT-1:0] id_req_b;
  logic                    id_use_a;
  logic                    id_use_b;
  logic                    id_w_en;
  logic [REG_ADDR_BIT-1:0] id_req_w;
  logic                    id_is_load;

  logic                    load_use;
  logic                    ex_collision_a;
  logic                    ex_collision_b;
  logic                    dm_collision_a;
  logic                    dm_collision_b;
  logic [CNT_BIT-1:0]      stall_cnt;
  logic [CNT_BIT-1:0]      flush_cnt;

  modport master (
    output hold, flush, id_valid, id_req_a, id_req_b, id_use_a, id_use_b,
           id_w_en, id_req_w, id_is_load,
    input  load_use, ex_collision_a, ex_collision_b, dm_collision_a,
           dm_collision_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  hold, flush, id_valid, id_req_a, id_req_b, id_use_a, id_use_b,
           id_w_en, id_req_w, id_is_load,
    output load_use, ex_collision_a, ex_collision_b, dm_collision_a,
           dm_collision_b, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_tracker_match.sv
// Compares one in-flight entry against one ID source operand.
// use_src must already be qualified with id_valid.
module hazard_match
  import hazard_tracker_pkg::*;
#(
  parameter int REG_ADDR_BIT = HZ_REG_ADDR_BIT
) (
  input  logic [hz_entry_bit(REG_ADDR_BIT)-1:0] entry,
  input  logic [REG_ADDR_BIT-1:0]               req,
  input  logic                                  use_src,
  output logic                                  hit
);

  localparam int VLD_OFS = hz_valid_ofs(REG_ADDR_BIT);
  localparam int WEN_OFS = hz_wen_ofs(REG_ADDR_BIT);

  // $0 is hardwired, so it never needs forwarding or a stall.
  assign hit = use_src && (req != '0) && entry[VLD_OFS] && entry[WEN_OFS] &&
               (entry[HZ_DEST_OFS +: REG_ADDR_BIT] == req);

endmodule

// File: rtl/hazard_tracker.sv
// Shadow EX/DM destination pipeline and hazard detection for the ID stage,
// with load-use stall and flush statistics.
module hazard_tracker
  import hazard_tracker_pkg::*;
#(
  parameter int REG_ADDR_BIT = HZ_REG_ADDR_BIT,
  parameter int CNT_BIT      = HZ_CNT_BIT
) (
  input  logic             clk,
  input  logic             rst,
  hazard_tracker_if.slave  hz
);

  localparam int EW  = hz_entry_bit(REG_ADDR_BIT);
  localparam int EX  = int'(STG_EX);
  localparam int DM  = int'(STG_DM);

  logic [HZ_NUM_STG-1:0][EW-1:0]           ent;
  logic [HZ_NUM_SRC-1:0][REG_ADDR_BIT-1:0] req;
  logic [HZ_NUM_SRC-1:0]                   use_src;
  logic [HZ_NUM_STG-1:0][HZ_NUM_SRC-1:0]   hit;
  logic [EW-1:0]                           ex_next;
  logic                                    load_use;
  logic                                    kill;
  logic [CNT_BIT-1:0]                      stall_cnt;
  logic [CNT_BIT-1:0]                      flush_cnt;

  assign req     = {hz.id_req_b, hz.id_req_a};
  assign use_src = {hz.id_valid & hz.id_use_b, hz.id_valid & hz.id_use_a};

  for (genvar s = 0; s < HZ_NUM_STG; s++) begin : g_stg
    for (genvar x = 0; x < HZ_NUM_SRC; x++) begin : g_src
      hazard_match #(.REG_ADDR_BIT(REG_ADDR_BIT)) u_match (
        .entry   (ent[s]),
        .req     (req[x]),
        .use_src (use_src[x]),
        .hit     (hit[s][x])
      );
    end
  end

  // A wrong-path consumer is discarded anyway, so flush suppresses the stall.
  assign load_use = (|hit[EX]) & ent[EX][HZ_LOAD_OFS] & ~hz.flush;

  assign hz.load_use       = load_use;
  assign hz.ex_collision_a = hit[EX][0] & ~load_use;
  assign hz.ex_collision_b = hit[EX][1] & ~load_use;
  assign hz.dm_collision_a = hit[DM][0] & ~hit[EX][0] & ~load_use;
  assign hz.dm_collision_b = hit[DM][1] & ~hit[EX][1] & ~load_use;
  assign hz.stall_cnt      = stall_cnt;
  assign hz.flush_cnt      = flush_cnt;

  assign kill    = hz.flush | load_use | ~hz.id_valid;
  assign ex_next = kill ? '0 : {1'b1, hz.id_w_en, hz.id_req_w, hz.id_is_load};

  always_ff @(posedge clk) begin
    if (rst) begin
      ent       <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!hz.hold) begin
      ent[DM]   <= ent[EX];
      ent[EX]   <= ex_next;
      stall_cnt <= stall_cnt + {{(CNT_BIT-1){1'b0}}, load_use};
      flush_cnt <= flush_cnt + {{(CNT_BIT-1){1'b0}}, hz.flush & hz.id_valid};
    end
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed-vector bench for hazard_tracker with a queue-based scoreboard.
module tb_hazard_tracker;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hazard_tracker_if #(.REG_ADDR_BIT(5), .CNT_BIT(32)) hz ();

  hazard_tracker #(.REG_ADDR_BIT(5), .CNT_BIT(32)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  typedef struct packed {
    logic [4:0]  haz;   // {load_use, ex_a, ex_b, dm_a, dm_b}
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t exp_q[$];
  string name_q[$];
  int checks = 0;
  int failures = 0;

  // Drive one cycle of ID inputs after the edge and queue the expected response.
  task automatic step(input string nm, input logic r, h, f, v,
                      input logic [4:0] ra, rb, input logic ua, ub, w,
                      input logic [4:0] rw, input logic ld,
                      input logic [4:0] e_haz, input int sc, fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; hz.hold = h; hz.flush = f; hz.id_valid = v;
    hz.id_req_a = ra; hz.id_req_b = rb; hz.id_use_a = ua; hz.id_use_b = ub;
    hz.id_w_en = w; hz.id_req_w = rw; hz.id_is_load = ld;
    e.haz = e_haz; e.sc = sc; e.fc = fc;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: outputs are valid every cycle once stimulus is applied.
  initial begin
    exp_t e;
    exp_t a;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a.haz = {hz.load_use, hz.ex_collision_a, hz.ex_collision_b,
                 hz.dm_collision_a, hz.dm_collision_b};
        a.sc = hz.stall_cnt;
        a.fc = hz.flush_cnt;
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL %s: got haz=%b stall=%0d flush=%0d, want haz=%b stall=%0d flush=%0d",
                   nm, a.haz, a.sc, a.fc, e.haz, e.sc, e.fc);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; hz.hold = 1'b0; hz.flush = 1'b0; hz.id_valid = 1'b1;
    hz.id_req_a = 5'd8; hz.id_req_b = 5'd8; hz.id_use_a = 1'b1; hz.id_use_b = 1'b1;
    hz.id_w_en = 1'b1; hz.id_req_w = 5'd8; hz.id_is_load = 1'b0;
    @(posedge clk);
    //    name          r  h  f  v  ra  rb  ua ub w  rw  ld  haz       sc fc
    step("reset",       1, 0, 0, 1, 8,  8,  1, 1, 1, 8,  0, 5'b00000, 0, 0);
    step("prod8",       0, 0, 0, 1, 1,  2,  1, 1, 1, 8,  0, 5'b00000, 0, 0);
    step("ex_fwd_a",    0, 0, 0, 1, 8,  3,  1, 1, 1, 10, 0, 5'b01000, 0, 0);
    step("dm_fwd_a",    0, 0, 0, 1, 8,  0,  1, 0, 0, 0,  0, 5'b00010, 0, 0);
    step("lw9",         0, 0, 0, 1, 29, 0,  1, 0, 1, 9,  1, 5'b00000, 0, 0);
    step("load_use_b",  0, 0, 0, 1, 4,  9,  1, 1, 1, 11, 0, 5'b10000, 0, 0);
    step("after_bub_b", 0, 0, 0, 1, 4,  9,  1, 1, 1, 11, 0, 5'b00001, 1, 0);
    step("bubble_inv",  0, 0, 0, 1, 9,  0,  1, 0, 0, 0,  0, 5'b00000, 1, 0);
    step("prod5_a",     0, 0, 0, 1, 0,  0,  0, 0, 1, 5,  0, 5'b00000, 1, 0);
    step("prod5_b",     0, 0, 0, 1, 0,  0,  0, 0, 1, 5,  0, 5'b00000, 1, 0);
    step("ex_over_dm",  0, 0, 0, 1, 5,  5,  1, 1, 0, 0,  0, 5'b01100, 1, 0);
    step("prod0",       0, 0, 0, 1, 0,  0,  0, 0, 1, 0,  0, 5'b00000, 1, 0);
    step("reg0_none",   0, 0, 0, 1, 0,  0,  1, 1, 0, 0,  0, 5'b00000, 1, 0);
    step("lw9_b",       0, 0, 0, 1, 0,  0,  0, 0, 1, 9,  1, 5'b00000, 1, 0);
    step("flush_wins",  0, 0, 1, 1, 0,  9,  0, 1, 1, 12, 0, 5'b00100, 1, 0);
    step("flushed_inv", 0, 0, 0, 1, 12, 9,  1, 1, 0, 0,  0, 5'b00001, 1, 1);
    step("lw7",         0, 0, 0, 1, 0,  0,  0, 0, 1, 7,  1, 5'b00000, 1, 1);
    step("hold_1",      0, 1, 0, 1, 7,  0,  1, 0, 1, 13, 0, 5'b10000, 1, 1);
    step("hold_2",      0, 1, 0, 1, 7,  0,  1, 0, 1, 13, 0, 5'b10000, 1, 1);
    step("hold_3",      0, 1, 0, 1, 7,  0,  1, 0, 1, 13, 0, 5'b10000, 1, 1);
    step("unhold_lu",   0, 0, 0, 1, 7,  0,  1, 0, 1, 13, 0, 5'b10000, 1, 1);
    step("unhold_dm",   0, 0, 0, 1, 7,  0,  1, 0, 1, 13, 0, 5'b00010, 2, 1);
    step("hold_flush",  0, 1, 1, 1, 0,  0,  0, 0, 0, 0,  0, 5'b00000, 2, 1);
    step("inv_id",      0, 0, 1, 0, 13, 0,  1, 0, 0, 0,  0, 5'b00000, 2, 1);
    step("dm13_a",      0, 0, 0, 1, 13, 0,  1, 0, 1, 14, 1, 5'b00010, 2, 1);
    step("mid_reset",   1, 0, 0, 0, 14, 0,  1, 0, 0, 0,  0, 5'b00000, 2, 1);
    step("post_reset",  0, 0, 0, 1, 14, 14, 1, 1, 0, 0,  0, 5'b00000, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
